// File: rtl/readout_collector.sv
// Readout collector: captures three ADC samples per frame on _RD strobes,
// packs them with the board number and queues the word in a FWFT FIFO.
module readout_collector #(
    parameter int DW    = 12,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                FRC_IN,
    input  logic                _RES_HARD,
    input  logic                COUNTER_F_GO,
    input  logic                _RD,
    input  logic                WRITE_BUFER,
    input  logic                CHENGE_ADRES_IN,
    input  logic [3:0]          COUNT_BOARD,
    input  logic [DW-1:0]       ADC_DATA,
    input  logic                OUT_READY,
    input  logic                CLR_OVF,
    output logic                OUT_VALID,
    output logic [6+3*DW-1:0]   OUT_DATA,
    output logic [AW:0]         FILL,
    output logic                OVERFLOW
);

    localparam int          OW       = 6 + 3 * DW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic          rd_q, wb_q, ca_q;
    logic          rd_fall, wb_rise, ca_rise;
    logic [1:0]    idx, ncap;
    logic [DW-1:0] s0, s1, s2;
    logic [1:0]    idx_c, ncap_c;
    logic [DW-1:0] s0_c, s1_c, s2_c;
    logic          cap, push, pop, full, acc, drop;
    logic [OW-1:0] push_word;
    logic [OW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;

    assign rd_fall = ~_RD & rd_q;
    assign wb_rise = WRITE_BUFER & ~wb_q;
    assign ca_rise = CHENGE_ADRES_IN & ~ca_q;

    assign cap  = rd_fall & COUNTER_F_GO & (ncap != 2'd3);
    assign push = wb_rise & COUNTER_F_GO;

    assign OUT_VALID = (cnt != '0);
    assign FILL      = cnt;
    assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : '0;

    assign pop  = OUT_VALID & OUT_READY;
    assign full = (cnt == FULL_CNT);
    assign acc  = push & (~full | pop);
    assign drop = push & full & ~pop;

    // Slot contents after this cycle's capture, so a coincident push sees it
    always_comb begin
        s0_c   = s0;
        s1_c   = s1;
        s2_c   = s2;
        idx_c  = idx;
        ncap_c = ncap;
        if (cap) begin
            case (idx)
                2'd0:    s0_c = ADC_DATA;
                2'd1:    s1_c = ADC_DATA;
                default: s2_c = ADC_DATA;
            endcase
            idx_c  = idx + 2'd1;
            ncap_c = ncap + 2'd1;
        end
    end

    assign push_word = {COUNT_BOARD, ncap_c, s2_c, s1_c, s0_c};

    // Strobe history for edge detection; runs even when sequencing is off
    always_ff @(posedge FRC_IN) begin
        if (!_RES_HARD) begin
            rd_q <= 1'b1;
            wb_q <= 1'b0;
            ca_q <= 1'b0;
        end else begin
            rd_q <= _RD;
            wb_q <= WRITE_BUFER;
            ca_q <= CHENGE_ADRES_IN;
        end
    end

    // Frame assembly: capture, clear on push, restart slot index on address change
    always_ff @(posedge FRC_IN) begin
        if (!_RES_HARD || !COUNTER_F_GO || push) begin
            idx  <= '0;
            ncap <= '0;
            s0   <= '0;
            s1   <= '0;
            s2   <= '0;
        end else if (ca_rise) begin
            idx  <= '0;
            ncap <= '0;
            s0   <= s0_c;
            s1   <= s1_c;
            s2   <= s2_c;
        end else begin
            idx  <= idx_c;
            ncap <= ncap_c;
            s0   <= s0_c;
            s1   <= s1_c;
            s2   <= s2_c;
        end
    end

    // FIFO storage; contents are don't-care until counted as occupied
    always_ff @(posedge FRC_IN) begin
        if (acc) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge FRC_IN) begin
        if (!_RES_HARD) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({acc, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky drop flag; a fresh drop outranks the clear
    always_ff @(posedge FRC_IN) begin
        if (!_RES_HARD) begin
            OVERFLOW <= 1'b0;
        end else if (drop) begin
            OVERFLOW <= 1'b1;
        end else if (CLR_OVF) begin
            OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_readout_collector.sv
// Testbench for readout_collector: frame table plus scoreboard-checked
// FIFO drain and hand-written corner-case sequences.
module tb_readout_collector;

    localparam int DW = 12;
    localparam int OW = 6 + 3 * DW;

    logic          clk;
    logic          res_n;
    logic          go;
    logic          rd_n;
    logic          wbuf;
    logic          chg;
    logic [3:0]    board;
    logic [DW-1:0] adc;
    logic          rdy;
    logic          clr;
    logic          vld;
    logic [OW-1:0] dout;
    logic [3:0]    fill;
    logic          ovf;

    int tests = 0;
    int fails = 0;

    logic [OW-1:0] sb[$];

    typedef struct {
        logic [3:0]          brd;
        int                  n;
        logic [3:0][DW-1:0]  d;
        logic [OW-1:0]       exp;
    } vec_t;

    vec_t vecs[5];

    readout_collector #(.DW(DW), .DEPTH(8), .AW(3)) dut (
        .FRC_IN          (clk),
        ._RES_HARD       (res_n),
        .COUNTER_F_GO    (go),
        ._RD             (rd_n),
        .WRITE_BUFER     (wbuf),
        .CHENGE_ADRES_IN (chg),
        .COUNT_BOARD     (board),
        .ADC_DATA        (adc),
        .OUT_READY       (rdy),
        .CLR_OVF         (clr),
        .OUT_VALID       (vld),
        .OUT_DATA        (dout),
        .FILL            (fill),
        .OVERFLOW        (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [OW-1:0] pack(input logic [3:0] b, input logic [1:0] n,
                                           input logic [DW-1:0] x2, input logic [DW-1:0] x1,
                                           input logic [DW-1:0] x0);
        return {b, n, x2, x1, x0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [DW-1:0] d);
        adc  = d;
        rd_n = 1'b0;
        tick();
        rd_n = 1'b1;
        tick();
    endtask

    task automatic wb();
        wbuf = 1'b1;
        tick();
        wbuf = 1'b0;
        tick();
    endtask

    task automatic drain();
        rdy = 1'b1;
        for (int i = 0; i < 100 && fill != 0; i++) tick();
        chk("drain_fill", 64'(fill), 64'd0);
        tick();
    endtask

    task automatic std_frame(input int k);
        board = 4'(k);
        rd(12'(k * 16 + 1));
        rd(12'(k * 16 + 2));
        rd(12'(k * 16 + 3));
    endtask

    function automatic logic [OW-1:0] std_word(input int k);
        return pack(4'(k), 2'd3, 12'(k * 16 + 3), 12'(k * 16 + 2), 12'(k * 16 + 1));
    endfunction

    // Scoreboard: every handshake pops one expected word
    always @(negedge clk) begin
        if (res_n && vld && rdy) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pop: got %h expected none", dout);
            end else begin
                chk("pop_data", 64'(dout), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        vecs[0] = '{4'd5, 3, {12'h0, 12'h333, 12'h222, 12'h111},
                    {4'd5, 2'd3, 12'h333, 12'h222, 12'h111}};
        vecs[1] = '{4'd6, 2, {12'h0, 12'h0, 12'hBBB, 12'hAAA},
                    {4'd6, 2'd2, 12'h000, 12'hBBB, 12'hAAA}};
        vecs[2] = '{4'd7, 4, {12'hABC, 12'h789, 12'h456, 12'h123},
                    {4'd7, 2'd3, 12'h789, 12'h456, 12'h123}};
        vecs[3] = '{4'hF, 0, {12'h0, 12'h0, 12'h0, 12'h0},
                    {4'hF, 2'd0, 12'h000, 12'h000, 12'h000}};
        vecs[4] = '{4'd0, 1, {12'h0, 12'h0, 12'h0, 12'hFFF},
                    {4'd0, 2'd1, 12'h000, 12'h000, 12'hFFF}};

        res_n = 1'b0;
        go    = 1'b0;
        rd_n  = 1'b1;
        wbuf  = 1'b0;
        chg   = 1'b0;
        board = '0;
        adc   = '0;
        rdy   = 1'b1;
        clr   = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(vld), 64'd0);
        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_data", 64'(dout), 64'd0);
        res_n = 1'b1;
        go    = 1'b1;
        tick();

        // Table of frames, each drained immediately
        for (int v = 0; v < 5; v++) begin
            board = vecs[v].brd;
            for (int j = 0; j < vecs[v].n; j++) rd(vecs[v].d[j]);
            sb.push_back(vecs[v].exp);
            chk("pre_push_valid", 64'(vld), 64'd0);
            wbuf = 1'b1;
            tick();
            wbuf = 1'b0;
            chk("valid_rise", 64'(vld), 64'd1);
            tick();
            chk("valid_one_cycle", 64'(vld), 64'd0);
        end

        // Backpressure: 9 frames into 8 slots
        rdy = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            std_frame(k);
            if (k <= 8) sb.push_back(std_word(k));
            wb();
        end
        chk("bp_fill", 64'(fill), 64'd8);
        chk("bp_ovf", 64'(ovf), 64'd1);
        chk("bp_head", 64'(dout), 64'(std_word(1)));
        tick();
        chk("bp_head_stable", 64'(dout), 64'(std_word(1)));
        drain();
        chk("bp_ovf_sticky", 64'(ovf), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf", 64'(ovf), 64'd0);

        // Push into a full FIFO while popping
        rdy = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            std_frame(k);
            sb.push_back(std_word(k));
            wb();
        end
        std_frame(9);
        sb.push_back(std_word(9));
        wbuf = 1'b1;
        rdy  = 1'b1;
        tick();
        wbuf = 1'b0;
        rdy  = 1'b0;
        chk("full_pop_fill", 64'(fill), 64'd8);
        chk("full_pop_ovf", 64'(ovf), 64'd0);
        chk("full_pop_head", 64'(dout), 64'(std_word(2)));
        tick();
        drain();

        // Capture coincident with push
        board = 4'd3;
        rd(12'h001);
        rd(12'h002);
        adc  = 12'h0C3;
        rd_n = 1'b0;
        wbuf = 1'b1;
        sb.push_back(pack(4'd3, 2'd3, 12'h0C3, 12'h002, 12'h001));
        tick();
        rd_n = 1'b1;
        wbuf = 1'b0;
        tick();
        drain();

        // Sequencing disabled
        go = 1'b0;
        rd(12'h555);
        wb();
        chk("gate_fill_a", 64'(fill), 64'd0);
        rd(12'h666);
        wb();
        chk("gate_fill_b", 64'(fill), 64'd0);
        go = 1'b1;
        tick();

        // Address change restarts slot index
        board = 4'd9;
        rd(12'h7FF);
        chg = 1'b1;
        tick();
        chg = 1'b0;
        tick();
        rd(12'h001);
        rd(12'h002);
        sb.push_back(pack(4'd9, 2'd2, 12'h000, 12'h002, 12'h001));
        wb();
        drain();

        // Reset mid-drain and mid-frame
        rdy = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            std_frame(k);
            wb();
        end
        chk("pre_rst_fill", 64'(fill), 64'd3);
        rd(12'hEEE);
        res_n = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(vld), 64'd0);
        chk("mid_rst_fill", 64'(fill), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        res_n = 1'b1;
        tick();
        board = 4'd2;
        rd(12'h123);
        sb.push_back(pack(4'd2, 2'd1, 12'h000, 12'h000, 12'h123));
        wb();
        drain();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
